fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that lets NREQ independent producers share the single write port of the half-full FIFO. Each producer gets a grant for bursts of up to BURST words. The arbiter stalls on the FIFO's inbusy and drives registered we/din into the FIFO. It sits directly in front of the FIFO write side, in the same clock domain.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA, 8, data width; must match the FIFO DATA
BURST, 4, maximum words accepted per grant before rotation (1..16)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
req  input  NREQ  per-requester write request; bit i = requester i
req_data  input  NREQ*DATA  flattened data; requester i on bits [i*DATA +: DATA]
ack  output  NREQ  per-requester accept strobe; word taken on a clk edge where ack[i]=1
grant  output  NREQ  one-hot current owner; all zero when idle
fifo_inbusy  input  1  FIFO inbusy (FIFO cannot take more writes)
fifo_we  output  1  FIFO write enable
fifo_din  output  DATA  FIFO write data
busy  output  1  high while state is BURST

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately without a clock edge): state=IDLE, grant=0, ack=0, fifo_we=0, fifo_din=0, busy=0, burst counter=0, last-owner pointer=NREQ-1 (so requester 0 wins first).
- States: IDLE, BURST.
- IDLE:
  - If req != 0, select the first requester with req set, searching from (last+1) mod NREQ upward with wrap.
  - Register grant=onehot(sel), cnt=0, and go to BURST.
  - The IDLE cycle never asserts ack.
  - If req==0, remain in IDLE.
- BURST, owner g:
  - ack[g] = req[g] & ~fifo_inbusy. This is combinational from registered grant/state. All other ack bits = 0.
  - On each ack edge: fifo_we<=1 and fifo_din<=req_data[g] on the next cycle, so FIFO write latency is 1 cycle after the accept edge. cnt<=cnt+1.
  - Without ack: fifo_we<=0. fifo_din holds its last value.
  - Exit to IDLE when either of these holds:
    - ack[g] is high and cnt==BURST-1 (burst complete), or
    - req[g]==0 (requester released; no word taken that cycle).
  - On exit: last<=g, grant<=0.
  - fifo_inbusy high with req[g] high: stay in BURST, ack=0, cnt unchanged (stall). The owner is never pre-empted while stalled.
- cnt width is clog2(BURST)+1. It is cleared on every entry to BURST.
- Fairness: the owner of a finished burst has the lowest priority in the next arbitration. With all NREQ requesting continuously, ownership cycles 0,1,2,...,NREQ-1,0.
- Throughput: a full burst takes 1 IDLE cycle plus BURST accept cycles. There is at most one fifo_we per clk.
- fifo_inbusy is sampled only in BURST. The FIFO raises inbusy one cycle after its fill reaches UPPER, so at most 2 extra words can land. The FIFO's UPPER margin (12 of 16) absorbs this; the arbiter adds no further lookahead.
- A requester dropping req mid-burst, then raising it again in the same IDLE cycle, is treated as a new request and subject to round-robin.
- Reset during BURST: fifo_we drops immediately. No partial word is written after rst deasserts. The pointer returns to the reset value.
- req bits for non-owners are ignored in BURST. req_data of non-owners is don't-care.
- No combinational path from fifo_inbusy to fifo_we. The only combinational paths are fifo_inbusy→ack and req→ack.

Test Plan:
- Reset then single requester: rst=0→1, req=4'b0001 held, data 0x10,0x11,0x12,0x13,0x14 → grant=0001 one cycle after req. ack high on 4 consecutive edges. fifo_we pulses 4 cycles carrying 0x10..0x13. One IDLE gap, then a new burst carrying 0x14.
- Round-robin: req=4'b1111 constant, BURST=4 → grant sequence 0001,0010,0100,1000,0001. Each owner accepts exactly 4 words. Total fifo_we=16 in 20 cycles.
- Backpressure: owner 2 mid-burst after 2 words, fifo_inbusy=1 for 5 cycles → ack=0 and fifo_we=0 for those cycles, grant stays 0100. After release, exactly 2 more words are accepted, then rotation.
- Early release: owner 1 drops req after 1 word while req[3]=1 → BURST exits, and the next grant=1000, not 0001.
- Async reset mid-burst: assert rst=0 between clk edges during BURST → fifo_we, ack and grant go 0 immediately. The first grant after release goes to requester 0.
- End-to-end with the FIFO (ADDR=4, UPPER=12): 4 requesters each streaming 10 words, no reads → FIFO stops at ≤14 entries, no overwrite. Data order within each requester is preserved.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Request/grant/write bundle between NREQ producers, the write arbiter and the FIFO write port.
// Handshake: req[i] is valid; a word moves from producer i on a rising clk edge where ack[i]=1, and req must hold until then.
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DATA = 8
);
  logic [NREQ-1:0]      req;
  logic [NREQ*DATA-1:0] req_data;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      grant;
  logic                 fifo_inbusy;
  logic                 fifo_we;
  logic [DATA-1:0]      fifo_din;
  logic                 busy;

  modport slave (
    input  req, req_data, fifo_inbusy,
    output ack, grant, fifo_we, fifo_din, busy
  );

  modport master (
    output req, req_data, fifo_inbusy,
    input  ack, grant, fifo_we, fifo_din, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter: NREQ producers share one FIFO write port, each owner taking up to
// BURST words per grant, stalling on fifo_inbusy, with registered fifo_we/fifo_din.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DATA  = 8,
  parameter int BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.slave  bus,
  output logic              state_dbg
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
  localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t          state;
  logic [LW-1:0]   owner;
  logic [LW-1:0]   last;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] grant_q;
  logic            we_q;
  logic [DATA-1:0] din_q;

  logic            owner_req;
  logic            owner_ack;
  logic [DATA-1:0] owner_data;
  logic [NREQ-1:0] ack_c;
  logic [LW-1:0]   sel;
  logic            sel_valid;

  // Owner-side view: ack only depends on registered state/owner plus live req and inbusy.
  always_comb begin
    owner_req  = bus.req[owner];
    owner_ack  = (state == ST_BURST) && owner_req && !bus.fifo_inbusy;
    owner_data = bus.req_data[int'(owner)*DATA +: DATA];
    ack_c        = '0;
    ack_c[owner] = owner_ack;
  end

  // Scan downward so the candidate closest to last+1 is written last and wins.
  always_comb begin
    sel       = last;
    sel_valid = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last) + k) % NREQ;
      if (bus.req[idx]) begin
        sel       = LW'(idx);
        sel_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      owner   <= '0;
      last    <= LAST_RST;
      cnt     <= '0;
      grant_q <= '0;
      we_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          we_q <= 1'b0;
          if (sel_valid) begin
            owner   <= sel;
            grant_q <= NREQ'(1) << sel;
            cnt     <= '0;
            state   <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (owner_ack) begin
            we_q  <= 1'b1;
            din_q <= owner_data;
            cnt   <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              last    <= owner;
              grant_q <= '0;
              state   <= ST_IDLE;
            end
          end else begin
            // A stall keeps the owner; only a released request ends the burst early.
            we_q <= 1'b0;
            if (!owner_req) begin
              last    <= owner;
              grant_q <= '0;
              state   <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack      = ack_c;
  assign bus.grant    = grant_q;
  assign bus.fifo_we  = we_q;
  assign bus.fifo_din = din_q;
  assign bus.busy     = (state == ST_BURST);
  assign state_dbg    = state;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a transaction-rule reference model
// and a FIFO fill model for the end-to-end backpressure case.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DATA  = 8;
  localparam int BURST = 4;
  localparam int UPPER = 12;

  logic clk;
  logic rst;
  logic state_dbg;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DATA(DATA)) bus();

  fifo_wr_arbiter #(.NREQ(NREQ), .DATA(DATA), .BURST(BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model state: who owns the port, how many words taken, who went last
  bit              m_active;
  int              m_owner;
  int              m_last;
  int              m_taken;
  logic            m_we;
  logic [DATA-1:0] m_din;
  logic [DATA-1:0] exp_q[$];

  logic [NREQ-1:0] ack_seen;
  int              ack_count;

  bit fifo_model_on;
  int fill;
  int fill_max;
  bit e2e_on;
  int seq_seen[NREQ];
  int sent[NREQ];

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_owner  = 0;
    m_last   = NREQ - 1;
    m_taken  = 0;
    m_we     = 1'b0;
    m_din    = '0;
    exp_q.delete();
  endtask

  task automatic end_burst();
    m_last   = m_owner;
    m_active = 1'b0;
  endtask

  // driver: one clock; inputs must already be set and stay put until this returns
  task automatic step();
    logic [NREQ-1:0] exp_ack;
    logic [NREQ-1:0] exp_grant;
    logic            pre_we;
    logic [DATA-1:0] d;
    int              id;
    #1;
    exp_ack = '0;
    if (m_active && bus.req[m_owner] && !bus.fifo_inbusy) exp_ack[m_owner] = 1'b1;
    check("ack", bus.ack, exp_ack);
    ack_seen  = exp_ack;
    ack_count += $countones(bus.ack);
    pre_we    = bus.fifo_we;
    @(posedge clk);
    #1;
    if (!m_active) begin
      m_we = 1'b0;
      if (bus.req != '0) begin
        m_owner  = rr_pick(m_last, bus.req);
        m_active = 1'b1;
        m_taken  = 0;
      end
    end else if (exp_ack != '0) begin
      m_we  = 1'b1;
      m_din = bus.req_data[m_owner*DATA +: DATA];
      exp_q.push_back(m_din);
      m_taken++;
      if (m_taken == BURST) end_burst();
    end else begin
      m_we = 1'b0;
      if (!bus.req[m_owner]) end_burst();
    end
    if (fifo_model_on) begin
      bus.fifo_inbusy = (fill >= UPPER);
      if (pre_we) fill++;
      if (fill > fill_max) fill_max = fill;
    end
    exp_grant = '0;
    if (m_active) exp_grant[m_owner] = 1'b1;
    check("grant", bus.grant, exp_grant);
    check("fifo_we", bus.fifo_we, m_we);
    check("fifo_din", bus.fifo_din, m_din);
    check("busy", bus.busy, m_active);
    check("state_dbg", state_dbg, m_active);
    // scoreboard: every FIFO write must be the oldest accepted word
    if (bus.fifo_we) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        d = exp_q.pop_front();
        check("sb_data", bus.fifo_din, d);
        if (e2e_on) begin
          id = int'(bus.fifo_din[7:4]);
          if (id < NREQ) begin
            check("e2e_order", bus.fifo_din[3:0], seq_seen[id][3:0]);
            seq_seen[id]++;
          end else begin
            check("e2e_id", id, 0);
          end
        end
      end
    end
  endtask

  logic [NREQ-1:0] rr_exp[5];
  int taken0;
  int acks_before;

  initial begin
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst             = 1'b0;
    bus.req         = '0;
    bus.req_data    = '0;
    bus.fifo_inbusy = 1'b0;
    fifo_model_on   = 1'b0;
    e2e_on          = 1'b0;
    fill            = 0;
    fill_max        = 0;
    ack_count       = 0;
    model_reset();

    // reset values
    #2;
    check("rst_grant", bus.grant, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_we", bus.fifo_we, 0);
    check("rst_din", bus.fifo_din, 0);
    check("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // single requester 0 streaming 0x10, 0x11, ...
    taken0  = 0;
    bus.req = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      bus.req_data[7:0] = 8'h10 + 8'(taken0);
      step();
      if (ack_seen[0]) taken0++;
    end
    check("single_words", taken0, 5);
    bus.req = '0;
    step();
    step();

    // async reset while requester 1 is mid-burst
    bus.req      = 4'b1111;
    bus.req_data = 32'hA3A2A1A0;
    step();
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    check("arst_we", bus.fifo_we, 0);
    check("arst_ack", bus.ack, 0);
    check("arst_grant", bus.grant, 0);
    check("arst_busy", bus.busy, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // round-robin with everyone requesting; first grant after reset goes to 0
    ack_count = 0;
    for (int i = 1; i <= 21; i++) begin
      bus.req_data = $urandom;
      step();
      if (i % 5 == 1) check("rr_grant", bus.grant, rr_exp[i / 5]);
      if (i == 20) check("rr_acks", ack_count, 16);
    end

    // backpressure on owner 2 after two words
    bus.req = 4'b0100;
    step();
    step();
    check("bp_grant", bus.grant, 4'b0100);
    step();
    step();
    bus.fifo_inbusy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold", bus.grant, 4'b0100);
    end
    bus.fifo_inbusy = 1'b0;
    acks_before = ack_count;
    step();
    step();
    check("bp_rest", ack_count - acks_before, 2);
    check("bp_rotate", bus.grant, 0);
    bus.req = '0;
    step();

    // early release of owner 1 while 3 and 0 request
    bus.req = 4'b0010;
    step();
    check("er_grant1", bus.grant, 4'b0010);
    step();
    bus.req = 4'b1001;
    step();
    step();
    check("er_grant3", bus.grant, 4'b1000);
    bus.req = '0;
    step();
    step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bus.req         = NREQ'($urandom_range(0, 15));
      bus.req_data    = $urandom;
      bus.fifo_inbusy = ($urandom_range(0, 3) == 0);
      step();
    end
    bus.req         = '0;
    bus.fifo_inbusy = 1'b0;
    step();
    step();
    step();

    // end to end: four streams of 10 words into a 16-deep FIFO with no reads
    for (int i = 0; i < NREQ; i++) begin
      sent[i]     = 0;
      seq_seen[i] = 0;
    end
    fill          = 0;
    fill_max      = 0;
    fifo_model_on = 1'b1;
    e2e_on        = 1'b1;
    for (int c = 0; c < 120; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        bus.req[i] = (sent[i] < 10);
        bus.req_data[i*DATA +: DATA] = 8'(i * 16 + sent[i]);
      end
      step();
      for (int i = 0; i < NREQ; i++) if (ack_seen[i]) sent[i]++;
    end
    check("e2e_fill_max_le14", (fill_max <= 14), 1);
    check("e2e_fill_ge12", (fill >= UPPER), 1);
    check("e2e_inbusy", bus.fifo_inbusy, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
